// File: rtl/imm_inst_encoder_pkg.sv
// Shared immediate-format codes, the canonical NOP and the request field bundle
// for the RV32I instruction encoder.
package imm_inst_encoder_pkg;

  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } fields_t;

  typedef struct packed {
    logic [2:0]  imm_type;
    logic [31:0] imm;
    fields_t     f;
  } req_t;

endpackage

// File: rtl/imm_inst_encoder_pack.sv
// Combinational packer: scatters the immediate into the RV32I field layout
// and flags immediates the chosen format cannot represent.
module imm_pack
  import imm_inst_encoder_pkg::*;
(
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  input  fields_t     f,
  output logic [31:0] inst,
  output logic        err
);

  // Sign-extension ranges must be all zeros or all ones to round-trip.
  logic se11, se12, se20;
  assign se11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign se12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign se20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    inst = NOP_INST;
    err  = 1'b1;
    case (imm_type)
      RTYPE: begin
        inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
        err  = 1'b0;
      end
      ITYPE: begin
        inst = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        err  = ~se11;
      end
      STYPE: begin
        inst = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
        err  = ~se11;
      end
      BTYPE: begin
        inst = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
        err  = ~se12 | imm[0];
      end
      UTYPE: begin
        inst = {imm[31:12], f.rd, f.opcode};
        err  = |imm[11:0];
      end
      JTYPE: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
        err  = ~se20 | imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with a saturating error counter.
// S1 holds the raw request, S2 holds the packed word and drives the outputs.
module imm_inst_encoder
  import imm_inst_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_type,
  input  logic [31:0]          imm,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [6:0]           funct7,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_cnt_clr
);

  logic        s1_valid, s2_valid;
  logic        s1_adv, s2_adv;
  req_t        s1_req;
  logic [31:0] pk_inst;
  logic        pk_err;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (in_valid && s1_adv && !flush)
        s1_req <= '{imm_type: imm_type, imm: imm,
                    f: '{funct7: funct7, rs2: rs2, rs1: rs1, funct3: funct3,
                         rd: rd, opcode: opcode}};
    end
  end

  imm_pack u_pack (
    .imm_type (s1_req.imm_type),
    .imm      (s1_req.imm),
    .f        (s1_req.f),
    .inst     (pk_inst),
    .err      (pk_err)
  );

  // Output data only loads with a real word, so it holds across stalls and bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_inst <= '0;
      out_err  <= 1'b0;
    end else begin
      if (flush)       s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid && !flush) begin
        out_inst <= pk_inst;
        out_err  <= pk_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_cnt_clr)
      err_cnt <= '0;
    else if (s2_valid && out_ready && out_err && (err_cnt != {ERR_CNT_W{1'b1}}))
      err_cnt <= err_cnt + 1'b1;
  end

endmodule
